// File: rtl/wb_writeback_pkg.sv
// Shared datapath constants for the write-back stage
// and the register file it feeds.
package wb_writeback_pkg;
  localparam int DATA_W = 32;
  localparam int NREG = 32;
  localparam int REG_AW = 5;
endpackage

// File: rtl/wb_writeback_reg_file.sv
// Architectural register file with r0 hardwired to zero
// and same-cycle bypass of the pending write-back.
module reg_file #(
  parameter int DATA_W = wb_writeback_pkg::DATA_W,
  parameter int NREG = wb_writeback_pkg::NREG
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [wb_writeback_pkg::REG_AW-1:0] wdst,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [wb_writeback_pkg::REG_AW-1:0] rs,
  input  logic [wb_writeback_pkg::REG_AW-1:0] rt,
  output logic [DATA_W-1:0]            rs_data,
  output logic [DATA_W-1:0]            rt_data
);
  import wb_writeback_pkg::*;

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && wdst != '0) begin
      regs[wdst] <= wdata;
    end
  end

  // r0 wins over bypass so a stray r0 write can never leak out
  always_comb begin
    rs_data = '0;
    if (rs == '0) begin
      rs_data = '0;
    end else if (we && wdst == rs) begin
      rs_data = wdata;
    end else begin
      rs_data = regs[rs];
    end
  end

  always_comb begin
    rt_data = '0;
    if (rt == '0) begin
      rt_data = '0;
    end else if (we && wdst == rt) begin
      rt_data = wdata;
    end else begin
      rt_data = regs[rt];
    end
  end
endmodule

// File: rtl/wb_writeback.sv
// MEM/WB pipeline register, write-back data select and
// the register file it writes.
module wb_writeback #(
  parameter int DATA_W = wb_writeback_pkg::DATA_W,
  parameter int NREG = wb_writeback_pkg::NREG
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic                         stall,
  input  logic                         flush,
  input  logic                         memRegWrite,
  input  logic                         memMemToReg,
  input  logic [wb_writeback_pkg::REG_AW-1:0] memRegDst,
  input  logic [DATA_W-1:0]            memAluResult,
  input  logic [DATA_W-1:0]            memReadData,
  input  logic [wb_writeback_pkg::REG_AW-1:0] rs,
  input  logic [wb_writeback_pkg::REG_AW-1:0] rt,
  output logic [DATA_W-1:0]            rsData,
  output logic [DATA_W-1:0]            rtData,
  output logic                         wbRegWrite,
  output logic [wb_writeback_pkg::REG_AW-1:0] wbRegDst,
  output logic [DATA_W-1:0]            wbData
);
  import wb_writeback_pkg::*;

  logic [DATA_W-1:0] sel_data;
  logic              sel_we;

  assign sel_data = memMemToReg ? memReadData : memAluResult;
  assign sel_we = memRegWrite && (memRegDst != '0);

  // flush outranks stall: a squashed entry must not linger
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wbRegWrite <= 1'b0;
      wbRegDst <= '0;
      wbData <= '0;
    end else if (flush) begin
      wbRegWrite <= 1'b0;
      wbRegDst <= '0;
      wbData <= '0;
    end else if (!stall) begin
      wbRegWrite <= sel_we;
      wbRegDst <= memRegDst;
      wbData <= sel_data;
    end
  end

  reg_file #(
    .DATA_W(DATA_W),
    .NREG(NREG)
  ) u_rf (
    .clk(Clk),
    .rst_n(Rst),
    .we(wbRegWrite),
    .wdst(wbRegDst),
    .wdata(wbData),
    .rs(rs),
    .rt(rt),
    .rs_data(rsData),
    .rt_data(rtData)
  );
endmodule

// File: doc/wb_writeback.md
WB_WRITEBACK -- requirements
Module: wb_writeback

Interface
REQ-001 Parameter DATA_W, default 32, datapath word width.
REQ-002 Parameter NREG, default 32, number of architectural registers; address width is 5.
REQ-003 Clk  input  1  single clock; all state updates on rising edge.
REQ-004 Rst  input  1  reset, asynchronous, active-low.
REQ-005 stall  input  1  hold MEM/WB contents this cycle.
REQ-006 flush  input  1  load a bubble into MEM/WB this cycle.
REQ-007 memRegWrite  input  1  MEM-stage instruction writes a register.
REQ-008 memMemToReg  input  1  1 = write-back data from memory, 0 = from ALU.
REQ-009 memRegDst  input  5  MEM-stage destination register.
REQ-010 memAluResult  input  DATA_W  MEM-stage ALU result.
REQ-011 memReadData  input  DATA_W  MEM-stage data-memory read value.
REQ-012 rs, rt  input  5 each  ID-stage read addresses.
REQ-013 rsData, rtData  output  DATA_W each  ID-stage read data.
REQ-014 wbRegWrite  output  1  WB-stage write enable; also the forwarding-unit source.
REQ-015 wbRegDst  output  5  WB-stage destination; also the forwarding-unit source.
REQ-016 wbData  output  DATA_W  WB-stage result; also the forwarding data source.

Function
REQ-017 MEM/WB register SHALL capture {regWrite, regDst, data} on rising Clk when stall=0 and flush=0.
REQ-018 Captured data SHALL be memReadData if memMemToReg=1, else memAluResult; the selection is made before the register, so wbData is a flop output.
REQ-019 Captured regWrite SHALL be memRegWrite AND (memRegDst != 0); a write to r0 never appears on wbRegWrite.
REQ-020 flush=1 SHALL load regWrite=0, regDst=0, data=0; flush has priority over stall.
REQ-021 stall=1 with flush=0 SHALL hold all MEM/WB fields unchanged.
REQ-022 Register file: NREG x DATA_W; on rising Clk, if wbRegWrite=1, reg[wbRegDst] <= wbData.
REQ-023 A stalled WB entry SHALL rewrite the same value each cycle (idempotent, permitted).
REQ-024 Reads SHALL be combinational: rsData = 0 if rs=0; else wbData if wbRegWrite=1 and wbRegDst=rs; else reg[rs]. rtData is defined identically with rt.
REQ-025 Latency: inputs sampled at edge N appear on wb* after edge N; the register-file update is visible via the array after edge N+1 and via bypass immediately after edge N.
REQ-026 rs=rt=wbRegDst SHALL bypass both ports in the same cycle.
REQ-027 reg[0] SHALL read 0 at all times, regardless of write attempts.

Reset
REQ-028 Rst=0 SHALL asynchronously clear wbRegWrite, wbRegDst, wbData and all register-file entries to 0.
REQ-029 While Rst=0, no register-file write SHALL occur; rsData and rtData SHALL read 0.
REQ-030 Reset deasserted mid-stall SHALL resume with the MEM/WB register empty (a bubble).

Structure
REQ-031 DATA_W, NREG and the register-address width SHALL live in the shared datapath package.
REQ-032 The register array and its bypass read logic SHALL be one sub-module, reg_file; the MEM/WB register and the data select SHALL be in wb_writeback.

Verification
REQ-033 memRegWrite=1, memRegDst=5, memMemToReg=0, memAluResult=0x1234 -> after 1 edge: wbRegWrite=1, wbRegDst=5, wbData=0x1234; rs=5 reads 0x1234 via bypass; after a further edge it reads 0x1234 with memRegWrite=0.
REQ-034 memRegDst=0, memRegWrite=1, data 0xFFFF -> wbRegWrite=0; rs=0 reads 0.
REQ-035 MEM/WB holds dst 7; then stall=1 and flush=1 together -> wbRegWrite=0, wbRegDst=0, wbData=0.
REQ-036 stall=1 for 3 cycles while inputs change -> wb* constant; reg[dst] equals the original wbData.
REQ-037 Rst=0 asserted between edges after writes to r3 and r9 -> outputs 0 immediately; rs=3 and rt=9 read 0 after release.
REQ-038 memMemToReg=1, memReadData=0xDEAD, memAluResult=0xBEEF, dst 4, rs=rt=4 -> rsData=rtData=0xDEAD.
